dac_spi_tx: RTL and testbench

Serial transmitter for a 12-bit DAC. It takes one sample per valid/ready handshake and sends it as a 16-bit frame, MSB first, on `sdata`. The frame is bracketed by an active-low `cs` (SYNC) and clocked by a divided `sclk`. It is the output-side counterpart of the ADC serial capture path, and drives the analog actuator from the controller's sample stream.

---
 rtl/dac_pkg.sv | 24 ++
 rtl/dac_sclk_div.sv | 48 ++++
 rtl/dac_spi_tx.sv | 122 ++++++++++++
 tb/tb_dac_spi_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared frame width, FSM state encoding, power-down codes and frame packing
// for the DAC serial transmitter.
package dac_pkg;

    localparam int unsigned FRAME_W  = 16;
    localparam int unsigned SAMPLE_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    function automatic logic [FRAME_W-1:0] pack_frame(input logic [1:0]          mode,
                                                      input logic [SAMPLE_W-1:0] data);
        return {2'b00, mode, data};
    endfunction

endpackage

// File: rtl/dac_sclk_div.sv
// Half-period tick counter for the DAC serial clock; also times the
// inter-frame gap when gap_mode is set.
module dac_sclk_div
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic gap_mode,
    output logic half_tick,
    output logic bit_end,
    output logic phase,
    output logic cnt_zero
);

    localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;

    assign last      = gap_mode ? CNT_W'(GAP_CYC - 1) : CNT_W'(CLK_DIV - 1);
    assign half_tick = (cnt == last);
    // phase=0 is the sclk-high half, so a bit ends when the low half runs out.
    assign bit_end   = half_tick && phase && !gap_mode;
    assign cnt_zero  = (cnt == '0);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (half_tick) begin
            cnt <= '0;
            if (!gap_mode) phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// 16-bit SPI-style frame transmitter for a 12-bit DAC (SYNC/SCLK/DIN).
// Define DAC_DUAL_CH_EN to add a second data lane for the dual-DAC module.
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned DATA_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    input  logic              in_valid,
    output logic              in_ready,
`ifdef DAC_DUAL_CH_EN
    input  logic [DATA_W-1:0] in_data_b,
    output logic              sdata_b,
`endif
    output logic              cs,
    output logic              sclk,
    output logic              sdata,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_W = $clog2(FRAME_W);

    state_t             state;
    logic [FRAME_W-1:0] shreg;
    logic [BIT_W-1:0]   bit_cnt;
`ifdef DAC_DUAL_CH_EN
    logic [FRAME_W-1:0] shreg_b;
`endif

    logic half_tick;
    logic bit_end;
    logic phase;
    logic cnt_zero;
    logic last_bit;
    logic div_clear;

    assign in_ready  = (state == IDLE);
    assign last_bit  = (state == SHIFT) && bit_end && (bit_cnt == BIT_W'(FRAME_W - 1));
    // Holding the divider clear in IDLE makes every frame start on a fresh half-period.
    assign div_clear = (state == IDLE) || last_bit;

    dac_sclk_div #(
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .clear     (div_clear),
        .gap_mode  (state == GAP),
        .half_tick (half_tick),
        .bit_end   (bit_end),
        .phase     (phase),
        .cnt_zero  (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs      <= 1'b1;
            sclk    <= 1'b1;
            sdata   <= 1'b0;
`ifdef DAC_DUAL_CH_EN
            shreg_b <= '0;
            sdata_b <= 1'b0;
`endif
        end else begin
            // Pins are a registered view of the previous state cycle, so cs
            // falls one edge after the accept and rises one edge after SHIFT ends.
            cs    <= (state != SHIFT);
            sclk  <= (state != SHIFT) || !phase;
            sdata <= (state == SHIFT) && shreg[FRAME_W-1];
            done  <= (state == GAP) && cnt_zero;
`ifdef DAC_DUAL_CH_EN
            sdata_b <= (state == SHIFT) && shreg_b[FRAME_W-1];
`endif
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg   <= pack_frame(in_mode, in_data);
`ifdef DAC_DUAL_CH_EN
                        shreg_b <= pack_frame(in_mode, in_data_b);
`endif
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        shreg   <= shreg << 1;
`ifdef DAC_DUAL_CH_EN
                        shreg_b <= shreg_b << 1;
`endif
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) state <= GAP;
                    end
                end
                GAP: begin
                    if (half_tick) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: a default-divider instance and a CLK_DIV=1
// instance, observed by a negedge frame monitor.
module tb_dac_spi_tx;
    import dac_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: defaults (CLK_DIV=4, GAP_CYC=4). Instance 1: CLK_DIV=1.
    logic [11:0] in_data0 = '0, in_data1 = '0;
    logic [1:0]  in_mode0 = '0, in_mode1 = '0;
    logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic        in_ready0, in_ready1, cs0, cs1, sclk0, sclk1, sdata0, sdata1;
    logic        busy0, busy1, done0, done1;
    logic        sdata_b0, sdata_b1;
`ifdef DAC_DUAL_CH_EN
    logic [11:0] in_data_b0 = '0, in_data_b1 = '0;
`else
    assign sdata_b0 = 1'b0;
    assign sdata_b1 = 1'b0;
`endif

    dac_spi_tx dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_mode(in_mode0),
        .in_valid(in_valid0), .in_ready(in_ready0),
`ifdef DAC_DUAL_CH_EN
        .in_data_b(in_data_b0), .sdata_b(sdata_b0),
`endif
        .cs(cs0), .sclk(sclk0), .sdata(sdata0), .busy(busy0), .done(done0)
    );

    dac_spi_tx #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_mode(in_mode1),
        .in_valid(in_valid1), .in_ready(in_ready1),
`ifdef DAC_DUAL_CH_EN
        .in_data_b(in_data_b1), .sdata_b(sdata_b1),
`endif
        .cs(cs1), .sclk(sclk1), .sdata(sdata1), .busy(busy1), .done(done1)
    );

    logic [1:0] m_cs, m_sclk, m_sdata, m_sdatab, m_done, m_rdy;
    assign m_cs     = {cs1, cs0};
    assign m_sclk   = {sclk1, sclk0};
    assign m_sdata  = {sdata1, sdata0};
    assign m_sdatab = {sdata_b1, sdata_b0};
    assign m_done   = {done1, done0};
    assign m_rdy    = {in_ready1, in_ready0};

    // Monitor state, one slot per instance.
    logic [15:0] bits[2], bits_b[2];
    int          falls[2], low_cnt[2], total_falls[2];
    int          first_fall[2], last_fall[2], rise_cyc[2], done_cyc[2], rdy_cyc[2];
    bit          frame_seen[2], done_seen[2];
    logic        prev_cs[2], prev_sclk[2], prev_rdy[2];

    initial begin
        for (int c = 0; c < 2; c++) begin
            bits[c] = '0; bits_b[c] = '0; falls[c] = 0; low_cnt[c] = 0;
            total_falls[c] = 0; first_fall[c] = 0; last_fall[c] = 0;
            rise_cyc[c] = 0; done_cyc[c] = 0; rdy_cyc[c] = 0;
            frame_seen[c] = 1'b0; done_seen[c] = 1'b0;
            prev_cs[c] = 1'b1; prev_sclk[c] = 1'b1; prev_rdy[c] = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (prev_sclk[c] && !m_sclk[c]) total_falls[c]++;
            if (prev_cs[c] && !m_cs[c]) begin
                bits[c] = '0; bits_b[c] = '0; falls[c] = 0; low_cnt[c] = 0;
            end
            if (!m_cs[c]) begin
                low_cnt[c]++;
                if (prev_sclk[c] && !m_sclk[c]) begin
                    bits[c]   = {bits[c][14:0], m_sdata[c]};
                    bits_b[c] = {bits_b[c][14:0], m_sdatab[c]};
                    falls[c]++;
                    if (falls[c] == 1) first_fall[c] = cyc;
                    last_fall[c] = cyc;
                end
            end
            if (!prev_cs[c] && m_cs[c]) begin
                frame_seen[c] = 1'b1;
                rise_cyc[c]   = cyc;
            end
            if (m_done[c] && !done_seen[c]) begin
                done_seen[c] = 1'b1;
                done_cyc[c]  = cyc;
            end
            if (m_rdy[c] && !prev_rdy[c]) rdy_cyc[c] = cyc;
            prev_cs[c]   = m_cs[c];
            prev_sclk[c] = m_sclk[c];
            prev_rdy[c]  = m_rdy[c];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic arm(input int c);
        frame_seen[c] = 1'b0;
        done_seen[c]  = 1'b0;
    endtask

    // Offer a sample and return the cycle stamp of the edge that accepted it.
    task automatic offer(input int c, input logic [11:0] d, input logic [11:0] db,
                         input logic [1:0] m, input string tag, output int acc);
        bit   took;
        logic r;
        took = 1'b0;
        acc  = 0;
        if (c == 0) begin
            in_data0 = d; in_mode0 = m; in_valid0 = 1'b1;
        end else begin
            in_data1 = d; in_mode1 = m; in_valid1 = 1'b1;
        end
`ifdef DAC_DUAL_CH_EN
        if (c == 0) in_data_b0 = db; else in_data_b1 = db;
`else
        if (db != 12'h000) $display("note: second-lane data ignored in single-channel build");
`endif
        for (int i = 0; i < 400 && !took; i++) begin
            @(negedge clk);
            r = m_rdy[c];
            @(posedge clk);
            #1;
            if (r) begin
                took = 1'b1;
                acc  = cyc;
            end
        end
        check({tag, "_accepted"}, 32'(took), 32'd1);
    endtask

    task automatic drop(input int c);
        if (c == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
    endtask

    task automatic wait_frame(input int c, input string tag);
        for (int i = 0; i < 1000 && !frame_seen[c]; i++) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_frame_end"}, 32'(frame_seen[c]), 32'd1);
    endtask

    initial begin
        int acc, acc2, rise1;
        bit reached;

        // Reset held with a request pending: pins must stay idle.
        in_valid0 = 1'b1; in_data0 = 12'hFFF;
        repeat (6) @(posedge clk);
        #1;
        check("rst_cs",    32'(cs0),    32'd1);
        check("rst_sclk",  32'(sclk0),  32'd1);
        check("rst_sdata", 32'(sdata0), 32'd0);
        check("rst_busy",  32'(busy0),  32'd0);
        check("rst_done",  32'(done0),  32'd0);
        check("rst_ready", 32'(in_ready0), 32'd1);
        check("rst_no_sclk_edges", 32'(total_falls[0]), 32'd0);
        in_valid0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single frame with defaults.
        arm(0);
        offer(0, 12'hA5C, 12'h000, PD_NORMAL, "a5c", acc);
        drop(0);
        wait_frame(0, "a5c");
        repeat (8) @(posedge clk);
        #1;
        check("a5c_bits",       32'(bits[0]),    32'h0A5C);
        check("a5c_falls",      32'(falls[0]),   32'd16);
        check("a5c_cs_low",     32'(low_cnt[0]), 32'd128);
        check("a5c_first_fall", 32'(first_fall[0] - acc), 32'd5);
        check("a5c_fall_span",  32'(last_fall[0] - first_fall[0]), 32'd120);
        check("a5c_done_at",    32'(done_cyc[0] - acc), 32'd129);
        check("a5c_cs_rise_at", 32'(rise_cyc[0] - acc), 32'd129);
        check("a5c_next_accept_at", 32'(rdy_cyc[0] + 1 - acc), 32'd133);

        // Back-to-back with in_valid held high.
        arm(0);
        offer(0, 12'h000, 12'h000, PD_NORMAL, "b2b_first", acc);
        in_data0 = 12'hFFF;
        wait_frame(0, "b2b_first");
        check("b2b_first_bits",  32'(bits[0]),  32'h0000);
        check("b2b_first_falls", 32'(falls[0]), 32'd16);
        rise1 = rise_cyc[0];
        arm(0);
        offer(0, 12'hFFF, 12'h000, PD_NORMAL, "b2b_second", acc2);
        drop(0);
        check("b2b_period",   32'(acc2 - acc),   32'd133);
        check("b2b_cs_high_before_accept", 32'(acc2 - rise1), 32'd4);
        wait_frame(0, "b2b_second");
        check("b2b_second_bits", 32'(bits[0]), 32'h0FFF);

        // Power-down mode bits land in frame bits 13:12.
        arm(0);
        offer(0, 12'h123, 12'h000, PD_HIZ, "mode", acc);
        drop(0);
        wait_frame(0, "mode");
        check("mode_bits", 32'(bits[0]), 32'h3123);

        // Reset in the middle of a frame, then a clean frame.
        arm(0);
        offer(0, 12'h3C3, 12'h000, PD_1K, "abort", acc);
        drop(0);
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            @(posedge clk);
            #1;
            if (falls[0] >= 8 && !m_cs[0]) reached = 1'b1;
        end
        check("abort_reached_fall7", 32'(reached), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_cs",    32'(cs0),   32'd1);
        check("abort_sclk",  32'(sclk0), 32'd1);
        check("abort_sdata", 32'(sdata0), 32'd0);
        check("abort_busy",  32'(busy0), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        arm(0);
        offer(0, 12'h555, 12'h000, PD_NORMAL, "after_abort", acc);
        drop(0);
        wait_frame(0, "after_abort");
        check("after_abort_bits",  32'(bits[0]),  32'h0555);
        check("after_abort_falls", 32'(falls[0]), 32'd16);

`ifdef DAC_DUAL_CH_EN
        arm(0);
        offer(0, 12'h0F0, 12'hF0F, PD_NORMAL, "dual", acc);
        drop(0);
        wait_frame(0, "dual");
        check("dual_bits_a", 32'(bits[0]),   32'h00F0);
        check("dual_bits_b", 32'(bits_b[0]), 32'h0F0F);
`endif

        // CLK_DIV=1 instance.
        arm(1);
        offer(1, 12'h801, 12'h000, PD_NORMAL, "div1", acc);
        drop(1);
        wait_frame(1, "div1");
        check("div1_bits",       32'(bits[1]),    32'h0801);
        check("div1_falls",      32'(falls[1]),   32'd16);
        check("div1_cs_low",     32'(low_cnt[1]), 32'd32);
        check("div1_first_fall", 32'(first_fall[1] - acc), 32'd2);
        check("div1_fall_span",  32'(last_fall[1] - first_fall[1]), 32'd30);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
